// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: read-priority scan reader vs. SPI packer writer.
// Writer owns region pointers; a bounded read run guarantees write progress.
module ram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int CMD_BASE   = 0,
  parameter int CMD_SIZE   = 64,
  parameter int DATA_BASE  = 64,
  parameter int DATA_SIZE  = 3072,
  parameter int MAX_RD_RUN = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              i_W_valid,
  input  logic [15:0]       i_W_data,
  input  logic              i_W_mode,
  output logic              o_W_ready,
  input  logic              i_R_req,
  input  logic [ADDR_W-1:0] i_R_addr,
  output logic              o_R_ack,
  output logic              o_R_valid,
  output logic [15:0]       o_R_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_wdata,
  output logic              o_ram_we,
  input  logic [15:0]       i_ram_rdata,
  output logic              o_frame_done
);

  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  localparam logic [ADDR_W-1:0] CMD_FIRST  = ADDR_W'(CMD_BASE);
  localparam logic [ADDR_W-1:0] CMD_LAST   = ADDR_W'(CMD_BASE + CMD_SIZE - 1);
  localparam logic [ADDR_W-1:0] DATA_FIRST = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] DATA_LAST  = ADDR_W'(DATA_BASE + DATA_SIZE - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(MAX_RD_RUN);

  logic [RUN_W-1:0]  run_q, run_d;
  logic [ADDR_W-1:0] cptr_q, cptr_d;
  logic [ADDR_W-1:0] dptr_q, dptr_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              fd_q, fd_d;
  logic [1:0]        rv_q, rv_d;
  logic              rd_gnt, wr_gnt;
  logic [ADDR_W-1:0] wa;

  assign rd_gnt = i_R_req & (~i_W_valid | (run_q < RUN_MAX));
  assign wr_gnt = i_W_valid & ~rd_gnt;

  assign o_R_ack      = rd_gnt;
  assign o_W_ready    = wr_gnt;
  assign o_ram_addr   = addr_q;
  assign o_ram_wdata  = wdata_q;
  assign o_ram_we     = we_q;
  assign o_frame_done = fd_q;
  assign o_R_valid    = rv_q[1];
  assign o_R_data     = rv_q[1] ? i_ram_rdata : 16'h0000;

  always_comb begin
    run_d   = run_q;
    cptr_d  = cptr_q;
    dptr_d  = dptr_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    fd_d    = 1'b0;
    rv_d    = {rv_q[0], rd_gnt};
    wa      = cptr_q;

    if (!i_W_valid || wr_gnt) begin
      run_d = '0;
    end else if (rd_gnt && run_q != RUN_MAX) begin
      run_d = run_q + 1'b1;
    end

    if (rd_gnt) begin
      addr_d = i_R_addr;
    end

    if (wr_gnt) begin
      we_d    = 1'b1;
      wdata_d = i_W_data;
      mode_d  = i_W_mode;
      if (i_W_mode) begin
        // a command->data transition always opens a fresh frame
        wa     = mode_q ? dptr_q : DATA_FIRST;
        fd_d   = (wa == DATA_LAST);
        dptr_d = fd_d ? DATA_FIRST : wa + 1'b1;
      end else begin
        wa     = cptr_q;
        cptr_d = (cptr_q == CMD_LAST) ? CMD_FIRST : cptr_q + 1'b1;
      end
      addr_d = wa;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      run_q   <= '0;
      cptr_q  <= CMD_FIRST;
      dptr_q  <= DATA_FIRST;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fd_q    <= 1'b0;
      rv_q    <= '0;
    end else begin
      run_q   <= run_d;
      cptr_q  <= cptr_d;
      dptr_q  <= dptr_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fd_q    <= fd_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table, directed sequences and
// randomized traffic against a region/offset reference model.
module tb_ram_port_arbiter;

  localparam int AW  = 12;
  localparam int CB  = 0;
  localparam int CS  = 8;
  localparam int DB  = 64;
  localparam int DS  = 4;
  localparam int MAX = 4;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          W_valid = 1'b0;
  logic [15:0]   W_data = '0;
  logic          W_mode = 1'b0;
  logic          R_req = 1'b0;
  logic [AW-1:0] R_addr = '0;
  logic          o_W_ready, o_R_ack, o_R_valid, o_ram_we, o_frame_done;
  logic [15:0]   o_R_data, o_ram_wdata;
  logic [AW-1:0] o_ram_addr;
  logic [15:0]   ram_rdata = '0;

  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(
    .ADDR_W(AW), .CMD_BASE(CB), .CMD_SIZE(CS),
    .DATA_BASE(DB), .DATA_SIZE(DS), .MAX_RD_RUN(MAX)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .i_W_valid(W_valid), .i_W_data(W_data), .i_W_mode(W_mode),
    .o_W_ready(o_W_ready),
    .i_R_req(R_req), .i_R_addr(R_addr),
    .o_R_ack(o_R_ack), .o_R_valid(o_R_valid), .o_R_data(o_R_data),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .o_ram_we(o_ram_we), .i_ram_rdata(ram_rdata),
    .o_frame_done(o_frame_done)
  );

  always #5 CLK = ~CLK;

  // RAM with one cycle read latency from the registered address
  always @(posedge CLK) begin
    if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
    ram_rdata <= mem[o_ram_addr];
  end

  // reference model state
  bit          m_we, m_fd, m_wr, m_last_mode;
  int          m_addr, m_wdata, m_run, m_coff, m_doff;
  bit          m_rv [2];
  int          m_rd [2];

  typedef int iq_t[$];
  iq_t wlog;
  iq_t exp_log;
  int  fd_cnt, fd_addr;

  typedef struct {
    logic rq;
    logic wv;
    logic exp_ack;
    logic exp_rdy;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_we = 0; m_fd = 0; m_wr = 0; m_last_mode = 0;
    m_addr = 0; m_wdata = 0; m_run = 0; m_coff = 0; m_doff = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
  endtask

  task automatic model_step();
    bit rd, wr;
    int off, a;
    chk("ram_we", o_ram_we, m_we);
    chk("ram_addr", o_ram_addr, m_addr);
    if (m_we) chk("ram_wdata", o_ram_wdata, m_wdata);
    chk("frame_done", o_frame_done, m_fd);
    chk("r_valid", o_R_valid, m_rv[1]);
    if (m_rv[1]) chk("r_data", o_R_data, m_rd[1]);
    if (o_ram_we) wlog.push_back(int'(o_ram_addr));
    if (o_frame_done) begin
      fd_cnt++;
      fd_addr = int'(o_ram_addr);
    end
    rd = R_req && (!W_valid || m_run < MAX);
    wr = W_valid && !rd;
    chk("r_ack", o_R_ack, rd);
    chk("w_ready", o_W_ready, wr);
    chk("ack_and_ready", o_R_ack & o_W_ready, 0);
    m_rv[1] = m_rv[0];
    m_rd[1] = m_rd[0];
    m_rv[0] = rd;
    m_we = 0;
    m_fd = 0;
    m_wr = wr;
    if (rd) begin
      m_rd[0] = int'(ref_mem[R_addr]);
      m_addr = int'(R_addr);
    end
    if (wr) begin
      if (W_mode) begin
        off = m_last_mode ? m_doff : 0;
        a = DB + off;
        m_fd = (off == DS - 1);
        m_doff = (off + 1) % DS;
      end else begin
        a = CB + m_coff;
        m_coff = (m_coff + 1) % CS;
      end
      m_last_mode = W_mode;
      m_we = 1;
      m_addr = a;
      m_wdata = int'(W_data);
      ref_mem[a] = W_data;
    end
    if (!W_valid || wr) m_run = 0;
    else if (rd && m_run < MAX) m_run++;
  endtask

  task automatic cycle(input logic rq, input logic [AW-1:0] ra,
                       input logic wv, input logic wm,
                       input logic [15:0] wd);
    @(posedge CLK);
    #1;
    R_req = rq; R_addr = ra; W_valid = wv; W_mode = wm; W_data = wd;
    @(negedge CLK);
    model_step();
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 16'h0);
  endtask

  // asserted between edges so a just-granted write never reaches the RAM
  task automatic do_reset();
    RST_n = 1'b0;
    R_req = 0; W_valid = 0; W_mode = 0; W_data = '0; R_addr = '0;
    m_reset();
    #1;
    chk("rst_we", o_ram_we, 0);
    chk("rst_rvalid", o_R_valid, 0);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_fd", o_frame_done, 0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
  endtask

  task automatic chk_log(input string nm, input iq_t e);
    chk({nm, "_count"}, wlog.size(), e.size());
    for (int i = 0; i < e.size() && i < wlog.size(); i++)
      chk(nm, wlog[i], e[i]);
  endtask

  initial begin
    logic wv, wm, rq;
    logic [15:0] wd;
    logic [AW-1:0] ra;

    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'(i * 37 + 5);
      ref_mem[i] = 16'(i * 37 + 5);
    end
    mem[10] = 16'hBEEF;
    ref_mem[10] = 16'hBEEF;
    m_reset();

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++)
      tbl[3 + i] = '{1'b1, 1'b1, (i % 5) != 4, (i % 5) == 4};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_we", o_ram_we, 0);
    chk("reset_addr", o_ram_addr, 0);
    chk("reset_wdata", o_ram_wdata, 0);
    chk("reset_rvalid", o_R_valid, 0);
    chk("reset_fd", o_frame_done, 0);
    RST_n = 1'b1;

    // writes only
    wlog.delete();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 16'(i));
      chk("wonly_ready", o_W_ready, 1);
    end
    idle();
    exp_log = '{0, 1, 2, 3, 4};
    chk_log("wonly_addr", exp_log);

    // mode switch and data-side restart
    @(negedge CLK);
    do_reset();
    wlog.delete();
    for (int i = 1; i <= 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 16'(i));
    cycle(1'b0, '0, 1'b1, 1'b1, 16'hFF00);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'hFE00);
    cycle(1'b0, '0, 1'b1, 1'b0, 16'h0004);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'hFD00);
    idle();
    exp_log = '{0, 1, 2, 64, 65, 3, 64};
    chk_log("mode_addr", exp_log);

    // data pointer wrap
    @(negedge CLK);
    do_reset();
    wlog.delete();
    fd_cnt = 0;
    fd_addr = -1;
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1, 16'(16'h100 + i));
    idle();
    exp_log = '{64, 65, 66, 67, 64};
    chk_log("wrap_addr", exp_log);
    chk("wrap_fd_count", fd_cnt, 1);
    chk("wrap_fd_addr", fd_addr, 67);

    // read latency
    @(negedge CLK);
    do_reset();
    cycle(1'b1, 12'd10, 1'b0, 1'b0, 16'h0);
    chk("rd_ack_n", o_R_ack, 1);
    idle();
    chk("rd_valid_n1", o_R_valid, 0);
    idle();
    chk("rd_valid_n2", o_R_valid, 1);
    chk("rd_data_n2", o_R_data, 16'hBEEF);

    // grant table incl. starvation guard
    @(negedge CLK);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rq, 12'(20 + i), tbl[i].wv, 1'b0, 16'(16'hA500 + i));
      chk("tbl_ack", o_R_ack, tbl[i].exp_ack);
      chk("tbl_ready", o_W_ready, tbl[i].exp_rdy);
    end
    idle();
    idle();

    // reset mid-stream
    @(negedge CLK);
    do_reset();
    wlog.delete();
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0D01);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0D02);
    cycle(1'b1, 12'd10, 1'b0, 1'b1, 16'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0D03);
    do_reset();
    idle();
    chk("mid_no_stale_valid", o_R_valid, 0);
    idle();
    chk("mid_no_stale_valid2", o_R_valid, 0);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0D04);
    idle();
    exp_log = '{64, 65, 64};
    chk_log("mid_addr", exp_log);

    // randomized traffic
    wv = 0; wm = 0; wd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!wv || m_wr) begin
        wv = ($urandom % 4) != 0;
        wm = ($urandom % 2) == 1;
        wd = 16'($urandom);
      end
      rq = ($urandom % 3) != 0;
      ra = 12'($urandom);
      cycle(rq, ra, wv, wm, wd);
    end
    idle();
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
